// File: rtl/volt_code_gen.sv
// Signed BCD voltage (0.1 mV units) to 16-bit two's-complement converter code.
// Define VOLT_CODE_ROUND_EN to round half up in the gain multiply; the default build truncates.
module volt_code_gen #(
  parameter int unsigned SCALE_K = 42950
) (
  input  logic        clk,
  input  logic        ad_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_sig,
  input  logic [19:0] in_dec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_code,
  output logic        out_sat,
  output logic        out_err
);

  typedef enum logic [2:0] {IDLE, CONV, MUL, SIGN, DONE} state_t;

  localparam logic [7:0] SIG_POS = 8'd43;
  localparam logic [7:0] SIG_NEG = 8'd45;

`ifdef VOLT_CODE_ROUND_EN
  localparam logic [32:0] RND = 33'd32768;
`else
  localparam logic [32:0] RND = 33'd0;
`endif

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [19:0] dec_q, dec_d;
  logic [16:0] acc_q, acc_d;
  logic        err_q, err_d;
  logic [16:0] mag_q, mag_d;
  logic [15:0] code_q, code_d;
  logic        sat_q, sat_d;
  logic        oerr_q, oerr_d;

  logic [3:0]  digit;
  logic [32:0] prod;

  assign digit = dec_q[19:16];
  assign prod  = 33'(acc_q) * 33'(SCALE_K) + RND;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dec_d   = dec_q;
    acc_d   = acc_q;
    err_d   = err_q;
    mag_d   = mag_q;
    code_d  = code_q;
    sat_d   = sat_q;
    oerr_d  = oerr_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = CONV;
        cnt_d   = 3'd0;
        neg_d   = (in_sig == SIG_NEG);
        dec_d   = in_dec;
        acc_d   = 17'd0;
        err_d   = (in_sig != SIG_POS) && (in_sig != SIG_NEG);
      end
      CONV: begin
        // Bad digits still accumulate so latency never depends on the input.
        acc_d = 17'(acc_q * 17'd10 + 17'(digit));
        err_d = err_q | (digit > 4'd9);
        dec_d = {dec_q[15:0], 4'h0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) state_d = MUL;
      end
      MUL: begin
        mag_d   = prod[32:16];
        state_d = SIGN;
      end
      SIGN: begin
        state_d = DONE;
        oerr_d  = err_q;
        sat_d   = 1'b0;
        if (err_q)                          code_d = 16'h0000;
        else if (!neg_q && mag_q > 17'd32767) begin
          code_d = 16'h7FFF;
          sat_d  = 1'b1;
        end
        else if (neg_q && mag_q >= 17'd32768) code_d = 16'h8000;
        else if (neg_q)                     code_d = 16'h0000 - mag_q[15:0];
        else                                code_d = mag_q[15:0];
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ad_reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      neg_q   <= 1'b0;
      dec_q   <= 20'd0;
      acc_q   <= 17'd0;
      err_q   <= 1'b0;
      mag_q   <= 17'd0;
      code_q  <= 16'h0000;
      sat_q   <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dec_q   <= dec_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      mag_q   <= mag_d;
      code_q  <= code_d;
      sat_q   <= sat_d;
      oerr_q  <= oerr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_code  = code_q;
  assign out_sat   = sat_q;
  assign out_err   = oerr_q;

endmodule
